handshake_master: RTL

Parametrised successor to the single-channel CPU-side send/ack machine. It arbitrates N_CH requesting sources round-robin and drives one four-phase send/ack link towards a peripheral. The block synchronises the incoming ack, aborts transfers on a configurable timeout, and reports completion and error per transfer. It sits between the CPU-side producers and the peripheral receive machine.

---
 rtl/handshake_pkg.sv | 17 +
 rtl/handshake_master_if.sv | 31 +++
 rtl/handshake_master_rr_arbiter.sv | 32 +++
 rtl/handshake_master.sv | 115 +++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared types for the round-robin four-phase send/ack master.
package handshake_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    RELEASE = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } hs_state_e;

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/handshake_master_if.sv
// Producer request side plus peripheral send/ack link of handshake_master.
interface handshake_master_if #(
  parameter int DATA_W = 4,
  parameter int N_CH   = 2
);
  import handshake_pkg::*;

  localparam int CH_W = ch_w(N_CH);

  logic [N_CH-1:0]        req_valid;
  logic [N_CH*DATA_W-1:0] req_data;
  logic [N_CH-1:0]        req_ready;
  logic                   send;
  logic [DATA_W-1:0]      dados;
  logic [CH_W-1:0]        ch_id;
  logic                   ack;
  logic                   done;
  logic                   err;
  logic [2:0]             estado;

  modport master (
    input  req_valid, req_data, ack,
    output req_ready, send, dados, ch_id, done, err, estado
  );

  modport slave (
    output req_valid, req_data, ack,
    input  req_ready, send, dados, ch_id, done, err, estado
  );

endinterface

// File: rtl/handshake_master_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import handshake_pkg::*;
#(
  parameter int N_CH = 2,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] idx
);

  int   c;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N_CH; i++) begin
      c = (int'(ptr) + i) % N_CH;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/handshake_master.sv
// N_CH-source round-robin front end driving one four-phase send/ack link,
// with ack synchroniser, per-phase timeout abort and done/err pulses.
module handshake_master
  import handshake_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int N_CH    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  handshake_master_if.master bus
);

  localparam int CH_W  = ch_w(N_CH);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  hs_state_e         state;
  logic              ack_m, ack_s;
  logic [CH_W-1:0]   rr_ptr, nxt_ptr, gnt_idx, ch_q;
  logic [N_CH-1:0]   gnt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dsel, dados_q;
  logic              send_q, done_q, err_q;
  logic              grant_ok, tmo;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // A stale ack (e.g. still high after an abort) holds off new grants.
  assign grant_ok = rst && (state == IDLE) && !ack_s && (|bus.req_valid);

  always_comb begin
    dsel = '0;
    for (int c = 0; c < N_CH; c++)
      if (gnt[c]) dsel = dsel | bus.req_data[c*DATA_W +: DATA_W];
  end

  assign tmo     = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1));
  assign nxt_ptr = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ack_m   <= 1'b0;
      ack_s   <= 1'b0;
      send_q  <= 1'b0;
      dados_q <= '0;
      ch_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rr_ptr  <= '0;
      cnt     <= '0;
    end else begin
      ack_m  <= bus.ack;
      ack_s  <= ack_m;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            dados_q <= dsel;
            ch_q    <= gnt_idx;
            send_q  <= 1'b1;
            cnt     <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          // ack wins over a timeout landing in the same cycle
          if (ack_s) begin
            send_q <= 1'b0;
            cnt    <= '0;
            state  <= RELEASE;
          end else if (tmo) begin
            send_q <= 1'b0;
            err_q  <= 1'b1;
            state  <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else if (tmo) begin
            err_q <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE, ERR: begin
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant_ok ? gnt : '0;
  assign bus.send      = send_q;
  assign bus.dados     = dados_q;
  assign bus.ch_id     = ch_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.estado    = state;

endmodule
